// File: rtl/daq_pkg.sv
// Shared types for the ADC acquisition path: scan FSM states, channel-index
// width helper and the sample record handed from the sequencer to the trigger engine.
package daq_pkg;

  localparam int NUM_CHANNELS_DEF = 16;
  localparam int ADC_WIDTH_DEF    = 12;

  function automatic int calc_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W_DEF = calc_ch_w(NUM_CHANNELS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CONVERT,
    NEXT,
    WAIT_PERIOD
  } scan_state_e;

  typedef struct packed {
    logic [ADC_WIDTH_DEF-1:0] data;
    logic [CH_W_DEF-1:0]      channel;
  } adc_sample_t;

endpackage

// File: rtl/mask_priority_picker.sv
// Combinational search for the lowest enabled channel at or above a start index.
import daq_pkg::*;

module mask_priority_picker #(
  parameter int  NUM_CHANNELS = 16,
  localparam int CH_W         = calc_ch_w(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] mask_i,
  input  logic [CH_W:0]           idx_i,
  output logic                    found_o,
  output logic [CH_W-1:0]         next_ch_o
);

  // Descending loop so the lowest qualifying index is the last one written.
  always_comb begin
    found_o   = 1'b0;
    next_ch_o = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(idx_i))) begin
        found_o   = 1'b1;
        next_ch_o = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic ADC channel scanner: walks the enabled channels in ascending order,
// forwards each conversion as a one-cycle beat, and flags timeouts and late scans.
import daq_pkg::*;

module adc_scan_sequencer #(
  parameter int  NUM_CHANNELS   = 16,
  parameter int  ADC_WIDTH      = 12,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int CH_W           = calc_ch_w(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_enable_i,
  input  logic [NUM_CHANNELS-1:0] channel_mask_i,
  input  logic [15:0]             scan_period_i,
  output logic                    adc_start_o,
  output logic [CH_W-1:0]         adc_channel_o,
  input  logic                    adc_done_i,
  input  logic [ADC_WIDTH-1:0]    adc_data_i,
  output logic [ADC_WIDTH-1:0]    data_out_o,
  output logic [CH_W-1:0]         channel_out_o,
  output logic                    data_valid_o,
  output logic                    scan_active_o,
  output logic                    timeout_err_o,
  output logic [7:0]              overrun_count_o
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  scan_state_e             state_q;
  logic [NUM_CHANNELS-1:0] mask_q;
  logic [15:0]             per_cnt_q;
  logic [TO_W-1:0]         to_cnt_q;
  logic                    ovr_seen_q;
  logic                    adc_start_q;
  logic [CH_W-1:0]         adc_channel_q;
  logic [ADC_WIDTH-1:0]    data_out_q;
  logic [CH_W-1:0]         channel_out_q;
  logic                    data_valid_q;
  logic                    scan_active_q;
  logic                    timeout_err_q;
  logic [7:0]              overrun_q;

  logic [NUM_CHANNELS-1:0] pick_mask_d;
  logic [CH_W:0]           pick_idx_d;
  logic                    pick_found;
  logic [CH_W-1:0]         pick_ch;
  logic                    period_due_d;
  logic                    scan_go_d;
  logic                    ovr_hit_d;

  // NEXT continues through the latched mask; IDLE and WAIT_PERIOD look at the
  // live mask because that is the value being latched for the new scan.
  always_comb begin
    pick_mask_d = channel_mask_i;
    pick_idx_d  = '0;
    if (state_q == NEXT) begin
      pick_mask_d = mask_q;
      pick_idx_d  = {1'b0, adc_channel_q} + (CH_W + 1)'(1);
    end
  end

  mask_priority_picker #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_picker (
    .mask_i    (pick_mask_d),
    .idx_i     (pick_idx_d),
    .found_o   (pick_found),
    .next_ch_o (pick_ch)
  );

  always_comb begin
    period_due_d = (scan_period_i == 16'd0) || (per_cnt_q >= (scan_period_i - 16'd1));
    scan_go_d    = scan_enable_i &&
                   ((state_q == IDLE) || ((state_q == WAIT_PERIOD) && period_due_d));
    ovr_hit_d    = scan_active_q && !ovr_seen_q && (scan_period_i != 16'd0) &&
                   (per_cnt_q == (scan_period_i - 16'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      per_cnt_q     <= '0;
      to_cnt_q      <= '0;
      ovr_seen_q    <= 1'b0;
      adc_start_q   <= 1'b0;
      adc_channel_q <= '0;
      data_out_q    <= '0;
      channel_out_q <= '0;
      data_valid_q  <= 1'b0;
      scan_active_q <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= '0;
    end else begin
      adc_start_q  <= 1'b0;
      data_valid_q <= 1'b0;

      if (per_cnt_q != 16'hFFFF) per_cnt_q <= per_cnt_q + 16'd1;

      // A late scan is flagged once; the restart happens when WAIT_PERIOD
      // finds the period already expired.
      if (ovr_hit_d) begin
        ovr_seen_q <= 1'b1;
        if (overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
      end

      if (scan_go_d) mask_q <= channel_mask_i;
      if (scan_go_d && pick_found) begin
        per_cnt_q     <= '0;
        ovr_seen_q    <= 1'b0;
        scan_active_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (scan_go_d && pick_found) begin
            adc_start_q   <= 1'b1;
            adc_channel_q <= pick_ch;
            state_q       <= SELECT;
          end
        end
        SELECT: begin
          to_cnt_q <= '0;
          state_q  <= CONVERT;
        end
        CONVERT: begin
          if (adc_done_i) begin
            data_out_q    <= adc_data_i;
            channel_out_q <= adc_channel_q;
            data_valid_q  <= 1'b1;
            state_q       <= NEXT;
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= NEXT;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        NEXT: begin
          if (pick_found) begin
            adc_start_q   <= 1'b1;
            adc_channel_q <= pick_ch;
            state_q       <= SELECT;
          end else begin
            scan_active_q <= 1'b0;
            state_q       <= WAIT_PERIOD;
          end
        end
        WAIT_PERIOD: begin
          if (!scan_enable_i) begin
            state_q <= IDLE;
          end else if (scan_go_d) begin
            if (pick_found) begin
              adc_start_q   <= 1'b1;
              adc_channel_q <= pick_ch;
              state_q       <= SELECT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_start_o     = adc_start_q;
  assign adc_channel_o   = adc_channel_q;
  assign data_out_o      = data_out_q;
  assign channel_out_o   = channel_out_q;
  assign data_valid_o    = data_valid_q;
  assign scan_active_o   = scan_active_q;
  assign timeout_err_o   = timeout_err_q;
  assign overrun_count_o = overrun_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer: an ADC model answers conversions,
// expected beats are queued by the stimulus and checked by a negedge monitor.
import daq_pkg::*;

module tb_adc_scan_sequencer;

  localparam int CONV_DLY = 4;

  logic        clk;
  logic        rst_n;
  logic        scan_enable;
  logic [15:0] channel_mask;
  logic [15:0] scan_period;
  logic        adc_start;
  logic [3:0]  adc_channel;
  logic        adc_done;
  logic [11:0] adc_data;
  logic [11:0] data_out;
  logic [3:0]  channel_out;
  logic        data_valid;
  logic        scan_active;
  logic        timeout_err;
  logic [7:0]  overrun_count;

  adc_scan_sequencer #(
    .NUM_CHANNELS   (16),
    .ADC_WIDTH      (12),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .scan_enable_i   (scan_enable),
    .channel_mask_i  (channel_mask),
    .scan_period_i   (scan_period),
    .adc_start_o     (adc_start),
    .adc_channel_o   (adc_channel),
    .adc_done_i      (adc_done),
    .adc_data_i      (adc_data),
    .data_out_o      (data_out),
    .channel_out_o   (channel_out),
    .data_valid_o    (data_valid),
    .scan_active_o   (scan_active),
    .timeout_err_o   (timeout_err),
    .overrun_count_o (overrun_count)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  int          mute_ch = 99;
  int          start_cnt = 0;
  int          beat_cnt = 0;
  adc_sample_t exp_q[$];
  int          starts_q[$];
  logic        sa_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ADC front-end model: answers CONV_DLY cycles after adc_start with 0x100+ch,
  // except on the muted channel.  It deliberately ignores rst_n.
  initial begin : adc_model
    int pend_cnt;
    int pend_ch;
    pend_cnt = 0;
    pend_ch  = 0;
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(posedge clk);
      #1;
      adc_done = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          adc_done = 1'b1;
          adc_data = 12'h100 + 12'(pend_ch);
          done_cyc = cyc;
        end
      end
      if (adc_start === 1'b1) begin
        pend_ch  = int'(adc_channel);
        pend_cnt = (pend_ch == mute_ch) ? 0 : CONV_DLY;
      end
    end
  end

  always @(negedge clk) begin : monitor
    adc_sample_t e;
    if (data_valid === 1'b1) begin
      beat_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got ch%0d data 0x%0h at cycle %0d, required no beat",
                 channel_out, data_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (channel_out !== e.channel || data_out !== e.data || cyc != done_cyc + 1) begin
          n_fail++;
          $display("FAIL beat: got ch%0d data 0x%0h at cycle %0d, required ch%0d data 0x%0h at cycle %0d",
                   channel_out, data_out, cyc, e.channel, e.data, done_cyc + 1);
        end
      end
    end
    if (scan_active === 1'b1 && !sa_prev) starts_q.push_back(cyc);
    sa_prev = (scan_active === 1'b1);
    if (adc_start === 1'b1) start_cnt++;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_beat(input int ch);
    adc_sample_t s;
    s.data    = 12'h100 + 12'(ch);
    s.channel = 4'(ch);
    exp_q.push_back(s);
  endfunction

  task automatic drain(input string name, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d beats still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_start(input string name, input int ch, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (adc_start === 1'b1 && int'(adc_channel) == ch) begin
        at = cyc;
        break;
      end
    end
    n_cmp++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL %s: no adc_start for ch%0d within %0d cycles, required one", name, ch, maxc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    scan_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    starts_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_adc_start"},     32'(adc_start),     32'd0);
    check({tag, "_adc_channel"},   32'(adc_channel),   32'd0);
    check({tag, "_data_out"},      32'(data_out),      32'd0);
    check({tag, "_channel_out"},   32'(channel_out),   32'd0);
    check({tag, "_data_valid"},    32'(data_valid),    32'd0);
    check({tag, "_scan_active"},   32'(scan_active),   32'd0);
    check({tag, "_timeout_err"},   32'(timeout_err),   32'd0);
    check({tag, "_overrun_count"}, 32'(overrun_count), 32'd0);
  endtask

  initial begin : stimulus
    int t;
    int sc;
    int bc;
    rst_n        = 1'b0;
    scan_enable  = 1'b0;
    channel_mask = '0;
    scan_period  = '0;

    do_reset();
    check_reset_vals("rst");

    // Basic scan: ch0 then ch2 each scan, scans 40 cycles apart.
    channel_mask = 16'h0005;
    scan_period  = 16'd40;
    for (int s = 0; s < 3; s++) begin
      push_beat(0);
      push_beat(2);
    end
    scan_enable = 1'b1;
    drain("basic_drain", 300);
    scan_enable = 1'b0;
    check("basic_scan_count", 32'(starts_q.size()), 32'd3);
    if (starts_q.size() >= 3) begin
      check("basic_period_1", 32'(starts_q[1] - starts_q[0]), 32'd40);
      check("basic_period_2", 32'(starts_q[2] - starts_q[1]), 32'd40);
    end
    check("basic_overrun", 32'(overrun_count), 32'd0);

    // Timeout on ch1; ch0 still delivered on the following scan.
    do_reset();
    mute_ch      = 1;
    channel_mask = 16'h0003;
    scan_period  = 16'd100;
    push_beat(0);
    push_beat(0);
    scan_enable = 1'b1;
    wait_start("timeout_ch1_start", 1, 30, t);
    if (t >= 0) begin
      while (cyc < t + 63) @(negedge clk);
      check("timeout_err_early", 32'(timeout_err), 32'd0);
      while (cyc < t + 66) @(negedge clk);
      check("timeout_err_set", 32'(timeout_err), 32'd1);
    end
    drain("timeout_drain", 200);
    scan_enable = 1'b0;
    repeat (80) @(negedge clk);
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);
    mute_ch = 99;

    // Empty mask: nothing happens until a channel is enabled.
    do_reset();
    channel_mask = 16'h0000;
    scan_period  = 16'd10;
    scan_enable  = 1'b1;
    sc = start_cnt;
    repeat (30) @(negedge clk);
    check("empty_no_start", 32'(start_cnt - sc), 32'd0);
    check("empty_scan_active", 32'(scan_active), 32'd0);
    push_beat(15);
    channel_mask = 16'h8000;
    drain("empty_ch15_drain", 50);
    scan_enable = 1'b0;

    // Overrun: 16 channels at 6 cycles each plus one WAIT cycle = 97 per scan.
    do_reset();
    channel_mask = 16'hFFFF;
    scan_period  = 16'd20;
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 16; c++) push_beat(c);
    scan_enable = 1'b1;
    drain("overrun_drain", 400);
    scan_enable = 1'b0;
    check("overrun_count_3", 32'(overrun_count), 32'd3);
    check("overrun_scan_count", 32'(starts_q.size()), 32'd3);
    if (starts_q.size() >= 3) begin
      check("overrun_spacing_1", 32'(starts_q[1] - starts_q[0]), 32'd97);
      check("overrun_spacing_2", 32'(starts_q[2] - starts_q[1]), 32'd97);
    end

    // Saturation: single channel, period 2, 7-cycle scans.
    do_reset();
    channel_mask = 16'h0001;
    scan_period  = 16'd2;
    for (int s = 0; s < 260; s++) push_beat(0);
    scan_enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() <= 257) break;
    end
    check("sat_count_after_3", 32'(overrun_count), 32'd3);
    drain("sat_drain", 3000);
    scan_enable = 1'b0;
    check("sat_count_255", 32'(overrun_count), 32'd255);

    // Mask change mid-scan, then disable during ch2 of a later scan.
    do_reset();
    channel_mask = 16'h000F;
    scan_period  = 16'd60;
    for (int c = 0; c < 4; c++) push_beat(c);
    push_beat(0);
    for (int c = 0; c < 4; c++) push_beat(c);
    scan_enable = 1'b1;
    wait_start("mask_ch1_start", 1, 30, t);
    channel_mask = 16'h0001;
    wait_start("mask_scanB_start", 0, 100, t);
    channel_mask = 16'h000F;
    wait_start("dis_ch2_start", 2, 120, t);
    scan_enable = 1'b0;
    drain("mask_dis_drain", 100);
    sc = start_cnt;
    repeat (100) @(negedge clk);
    check("dis_no_more_starts", 32'(start_cnt - sc), 32'd0);
    check("dis_scan_active", 32'(scan_active), 32'd0);
    check("dis_last_channel", 32'(channel_out), 32'd3);

    // Reset during a conversion; the model's late adc_done must be ignored.
    channel_mask = 16'h0001;
    scan_period  = 16'd50;
    scan_enable  = 1'b1;
    wait_start("rstconv_start", 0, 20, t);
    @(negedge clk);
    rst_n       = 1'b0;
    scan_enable = 1'b0;
    bc = beat_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("rstconv");
    repeat (10) @(negedge clk);
    check("rstconv_no_beat", 32'(beat_cnt - bc), 32'd0);
    check("rstconv_no_start", 32'(adc_start), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Producer side of the sample stream feeding `derivative_threshold_engine`. It scans the enabled ADC channels in ascending order and issues one conversion request per channel to the ADC front end. Each result is forwarded as a single-cycle `data_valid` beat carrying `data_out`/`channel_out`, the exact triple the trigger engine consumes. Scans repeat at a programmable period, and the block flags conversion timeouts and scan overruns.

## Interface
- `NUM_CHANNELS`, 16, number of ADC channels; `CH_W = $clog2(NUM_CHANNELS)`
- `ADC_WIDTH`, 12, sample width
- `TIMEOUT_CYCLES`, 64, maximum cycles from `adc_start` to `adc_done`
- `clk` in 1: single clock; all logic is posedge
- `rst_n` in 1: synchronous, active-low reset
- `scan_enable` in 1: level; 1 runs periodic scans; 0 stops after the current scan completes
- `channel_mask` in NUM_CHANNELS: channel enables, latched at each scan start
- `scan_period` in 16: cycles from one scan start to the next; 0 means back-to-back scans
- `adc_start` out 1: one-cycle conversion request
- `adc_channel` out CH_W: mux select, held from `adc_start` until done or timeout
- `adc_done` in 1: one-cycle conversion-complete strobe
- `adc_data` in ADC_WIDTH: result, valid when `adc_done`=1
- `data_out` out ADC_WIDTH: sample to the trigger engine
- `channel_out` out CH_W: channel of `data_out`
- `data_valid` out 1: one-cycle beat; no backpressure
- `scan_active` out 1: high from scan start until the last channel of the scan completes
- `timeout_err` out 1: sticky; cleared only by reset
- `overrun_count` out 8: saturating count of scans that started late

## Operation
- FSM states: IDLE, SELECT, CONVERT, NEXT, WAIT_PERIOD.
- **IDLE.** When `scan_enable`=1, latch `channel_mask` into `mask_q`.
  - If `mask_q`≠0: start the period counter at 0, set `scan_active`, go to SELECT.
  - If `mask_q`=0: stay in IDLE and emit nothing. Re-sample the mask every cycle.
- **SELECT.** Choose the lowest set bit of `mask_q` at index ≥ `idx`, where `idx`=0 at scan start. Drive `adc_channel` to that bit, pulse `adc_start`, clear the timeout counter, go to CONVERT.
- **CONVERT.**
  - On `adc_done`: register `adc_data` and `adc_channel` into `data_out`/`channel_out`, and set `data_valid` on the next cycle.
  - If the timeout counter reaches `TIMEOUT_CYCLES-1` without `adc_done`: set `timeout_err`, emit no beat, and treat the channel as complete.
  - In both cases go to NEXT.
  - An `adc_done` seen outside CONVERT is ignored.
- **NEXT.** Set `idx` = current channel + 1.
  - If another set bit of `mask_q` exists at index ≥ `idx`: go to SELECT.
  - Otherwise: clear `scan_active` and go to WAIT_PERIOD.
- **WAIT_PERIOD.**
  - If `scan_enable`=0: go to IDLE.
  - Otherwise, when the period counter ≥ `scan_period-1`, or `scan_period`=0: re-latch the mask, restart the counter, and go to SELECT, or to IDLE if the new mask is 0.
- **Overrun.** The period counter keeps running during the scan. If it reaches `scan_period-1` while `scan_active`=1 and `scan_period`≠0:
  - increment `overrun_count`, saturating at 255;
  - the next scan starts the cycle after the current scan ends.
  - At most one overrun is counted per scan.
- Changes to `channel_mask` mid-scan have no effect until the next scan start.
- Deasserting `scan_enable` mid-scan: finish the remaining channels, then go to IDLE.

## Timing
- **Reset values:** `adc_start`=0, `adc_channel`=0, `data_out`=0, `channel_out`=0, `data_valid`=0, `scan_active`=0, `timeout_err`=0, `overrun_count`=0; FSM in IDLE.
- **Scan start:** `scan_enable` sampled at 1 in cycle t → SELECT at t+1 → `adc_start` at t+1.
- **Sample latency:** `adc_done` at cycle d → `data_valid`, `data_out`, `channel_out` all valid at d+1, for exactly one cycle.
- **Channel-to-channel gap:** `adc_done` at d → next `adc_start` at d+2 (NEXT at d+1, SELECT at d+2).
- **Reset mid-conversion:** all state returns to reset values on the next edge. A later `adc_done` is ignored in IDLE.

## Structure
- Package `daq_pkg` holds:
  - `scan_state_e` enum;
  - `CH_W` as a function of `NUM_CHANNELS`;
  - a shared `adc_sample_t` struct {`data`, `channel`}, reusable by the trigger engine.
- Sub-module `mask_priority_picker` is combinational. It takes `mask_q` and `idx` and returns {`found`, `next_ch`}, the lowest set bit at index ≥ `idx`.

## Test plan
1. **Basic scan.** `channel_mask`=0x0005, `scan_period`=40, ADC model asserts `adc_done` 4 cycles after `adc_start` with data `0x100+ch` → per scan, beats (ch0, 0x100) then (ch2, 0x102), and scan starts exactly 40 cycles apart.
2. **Timeout.** Model never answers on ch1, mask=0x0003 → after 64 cycles `timeout_err`=1, no beat for ch1, ch0 still emitted next scan.
3. **Empty mask.** Mask=0 with `scan_enable`=1 → no `adc_start`, no `data_valid`, `scan_active`=0. Setting mask to 0x8000 → the next beat carries ch15.
4. **Overrun.** Mask=0xFFFF, `scan_period`=20, 4-cycle conversions → `overrun_count` increments once per scan. Scans run back-to-back with no idle gap; count saturates at 255.
5. **Mask change and disable mid-scan.** Change mask 0x000F→0x0001 during ch1 conversion → ch2 and ch3 still emitted this scan, only ch0 next scan. Dropping `scan_enable` during ch2 → ch3 emitted, then IDLE.
6. **Reset mid-conversion.** `rst_n`=0 while in CONVERT → all outputs return to reset values. A late `adc_done` produces no `data_valid`.
